// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: accepts instruction beats, encodes them and
// streams the 32-bit words into instruction memory starting at address 0.
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [4:0]  mnem,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [5:0]  shamt,
   input  logic [25:0] imm,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic [8:0]  count,
   output logic        done,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_MNEM  = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_OVF   = 2'b11;

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [8:0]  count_q, count_d;
   logic        done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic        last_q, last_d;

   logic [31:0] enc_word;
   logic [1:0]  enc_err;
   logic        i_ok, d_ok, cb_ok;

   function automatic logic [31:0] r_fmt(input logic [10:0] op, input logic [4:0] m,
                                         input logic [5:0] sh, input logic [4:0] n,
                                         input logic [4:0] d);
      return {op, m, sh, n, d};
   endfunction

   function automatic logic [31:0] i_fmt(input logic [9:0] op, input logic [11:0] im,
                                         input logic [4:0] n, input logic [4:0] d);
      return {op, im, n, d};
   endfunction

   function automatic logic [31:0] d_fmt(input logic [10:0] op, input logic [8:0] im,
                                         input logic [4:0] n, input logic [4:0] t);
      return {op, im, 2'b00, n, t};
   endfunction

   // Range checks: the discarded upper bits must be a pure zero/sign extension.
   always_comb begin
      i_ok     = (imm[25:12] == '0);
      d_ok     = (&imm[25:8]) | ~(|imm[25:8]);
      cb_ok    = (&imm[25:18]) | ~(|imm[25:18]);
      enc_word = '0;
      enc_err  = ERR_OK;
      case (mnem)
         5'd0:  enc_word = {6'b000101, imm};
         5'd1:  begin enc_word = {8'b10110100, imm[18:0], rd}; if (!cb_ok) enc_err = ERR_RANGE; end
         5'd2:  begin enc_word = {8'b10110101, imm[18:0], rd}; if (!cb_ok) enc_err = ERR_RANGE; end
         5'd3:  begin enc_word = i_fmt(10'b1001000100, imm[11:0], rn, rd); if (!i_ok) enc_err = ERR_RANGE; end
         5'd4:  begin enc_word = i_fmt(10'b1001001000, imm[11:0], rn, rd); if (!i_ok) enc_err = ERR_RANGE; end
         5'd5:  begin enc_word = i_fmt(10'b1101001000, imm[11:0], rn, rd); if (!i_ok) enc_err = ERR_RANGE; end
         5'd6:  begin enc_word = i_fmt(10'b1011001000, imm[11:0], rn, rd); if (!i_ok) enc_err = ERR_RANGE; end
         5'd7:  begin enc_word = i_fmt(10'b1101000100, imm[11:0], rn, rd); if (!i_ok) enc_err = ERR_RANGE; end
         5'd8:  enc_word = r_fmt(11'b10001011000, rm, 6'd0, rn, rd);
         5'd9:  enc_word = r_fmt(11'b10001010000, rm, 6'd0, rn, rd);
         5'd10: enc_word = r_fmt(11'b11010110000, 5'd0, 6'd0, rn, rn);
         5'd11: enc_word = r_fmt(11'b11001010000, rm, 6'd0, rn, rd);
         5'd12: enc_word = r_fmt(11'b11010011011, 5'd0, shamt, rn, rd);
         5'd13: enc_word = r_fmt(11'b11010011010, 5'd0, shamt, rn, rd);
         5'd14: enc_word = r_fmt(11'b10101010000, rm, 6'd0, rn, rd);
         5'd15: enc_word = r_fmt(11'b11001011000, rm, 6'd0, rn, rd);
         5'd16: begin enc_word = d_fmt(11'b11111000010, imm[8:0], rn, rd); if (!d_ok) enc_err = ERR_RANGE; end
         5'd17: begin enc_word = d_fmt(11'b11111000000, imm[8:0], rn, rd); if (!d_ok) enc_err = ERR_RANGE; end
         default: enc_err = ERR_MNEM;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      done_d  = done_q;
      err_d   = err_q;
      last_d  = last_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = ACCEPT;
               addr_d  = '0;
               count_d = '0;
               done_d  = 1'b0;
               err_d   = ERR_OK;
            end
         end
         ACCEPT: begin
            if (in_valid) begin
               if (enc_err != ERR_OK) begin
                  err_d   = enc_err;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  wdata_d = enc_word;
                  last_d  = in_last;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            count_d = count_q + 9'd1;
            // The address saturates at the top of memory instead of wrapping.
            if (addr_q != 8'hFF) addr_d = addr_q + 8'd1;
            if (last_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (addr_q == 8'hFF) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = ERR_OVF;
            end else begin
               state_d = ACCEPT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= ERR_OK;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         done_q  <= done_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end

   assign in_ready   = (state_q == ACCEPT);
   assign imem_we    = (state_q == WRITE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;
   assign done       = done_q;
   assign err_code   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: single-beat vector table plus
// multi-beat loads, overflow, mid-write reset and stray in_valid sequences.
module tb_instr_encoder;

   logic        clk, rst_n, start, in_valid, in_ready, in_last;
   logic [4:0]  mnem, rd, rn, rm;
   logic [5:0]  shamt;
   logic [25:0] imm;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  count;
   logic        done;
   logic [1:0]  err_code;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int wr_base;

   instr_encoder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .mnem(mnem), .rd(rd), .rn(rn),
      .rm(rm), .shamt(shamt), .imm(imm), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
      .done(done), .err_code(err_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (imem_we) wr_cnt++;

   typedef struct {
      string       name;
      logic [4:0]  mnem, rd, rn, rm;
      logic [5:0]  shamt;
      logic [25:0] imm;
      logic [31:0] word;
      logic [1:0]  err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input string nm, input int mn, input int d, input int n,
                                   input int m, input int sh, input int im,
                                   input logic [31:0] w, input int e);
      vec_t v;
      v.name = nm; v.mnem = 5'(mn); v.rd = 5'(d); v.rn = 5'(n); v.rm = 5'(m);
      v.shamt = 6'(sh); v.imm = 26'(im); v.word = w; v.err = 2'(e);
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ready"}, 64'(in_ready), 0);
      chk({nm, "_we"},    64'(imem_we), 0);
      chk({nm, "_addr"},  64'(imem_addr), 0);
      chk({nm, "_wdata"}, 64'(imem_wdata), 0);
      chk({nm, "_count"}, 64'(count), 0);
      chk({nm, "_done"},  64'(done), 0);
      chk({nm, "_err"},   64'(err_code), 0);
   endtask

   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic send(input logic [4:0] mn, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [5:0] sh, input logic [25:0] im,
                       input logic last);
      int k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("wait_in_ready", 64'(in_ready), 1);
      mnem = mn; rd = d; rn = n; rm = m; shamt = sh; imm = im; in_last = last;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      mnem = '0; rd = '0; rn = '0; rm = '0; shamt = '0; imm = '0;

      add_vec("ADD",    8,  3, 1, 2,  0, 5,       32'h8B020023, 0);
      add_vec("ADDI",   3,  1, 0, 0,  0, 5,       32'h91001401, 0);
      add_vec("LDUR",  16,  2, 1, 0,  0, -8,      32'hF85F8022, 0);
      add_vec("CBZ",    1,  4, 0, 0,  0, -2,      32'hB4FFFFC4, 0);
      add_vec("B_pos",  0,  0, 0, 0,  0, 1,       32'h14000001, 0);
      add_vec("B_neg",  0,  0, 0, 0,  0, -1,      32'h17FFFFFF, 0);
      add_vec("BR",    10,  5, 30, 9, 4, 0,       32'hD60003DE, 0);
      add_vec("LSL",   12,  1, 2, 7,  3, 0,       32'hD3600C41, 0);
      add_vec("SUB",   15,  0, 0, 31, 5, 0,       32'hCB1F0000, 0);
      add_vec("ANDI_max", 4, 0, 0, 0, 0, 4095,    32'h923FFC00, 0);
      add_vec("STUR_max", 17, 4, 3, 0, 0, 255,    32'hF80FF064, 0);
      add_vec("LDUR_min", 16, 0, 0, 0, 0, -256,   32'hF8500000, 0);
      add_vec("CBNZ_max", 2, 1, 0, 0, 0, 262143,  32'hB57FFFE1, 0);
      add_vec("ADDI_4096", 3, 1, 0, 0, 0, 4096,   32'h0, 2);
      add_vec("ADDI_neg",  3, 1, 0, 0, 0, -1,     32'h0, 2);
      add_vec("LDUR_256", 16, 1, 0, 0, 0, 256,    32'h0, 2);
      add_vec("STUR_m257", 17, 1, 0, 0, 0, -257,  32'h0, 2);
      add_vec("CBZ_hi",  1, 1, 0, 0, 0, 262144,   32'h0, 2);
      add_vec("CBNZ_lo", 2, 1, 0, 0, 0, -262145,  32'h0, 2);
      add_vec("MNEM20", 20, 1, 0, 0, 0, 0,        32'h0, 1);
      add_vec("MNEM18", 18, 1, 0, 0, 0, 0,        32'h0, 1);

      #12;
      chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 64'(in_ready), 0);

      // Table: each vector is a one-beat load.
      foreach (vecs[i]) begin
         wr_base = wr_cnt;
         do_start();
         send(vecs[i].mnem, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].shamt, vecs[i].imm, 1'b1);
         if (vecs[i].err == 2'b00) begin
            chk({vecs[i].name, "_we"},    64'(imem_we), 1);
            chk({vecs[i].name, "_addr"},  64'(imem_addr), 0);
            chk({vecs[i].name, "_wdata"}, 64'(imem_wdata), 64'(vecs[i].word));
            @(negedge clk);
            chk({vecs[i].name, "_count"}, 64'(count), 1);
         end else begin
            chk({vecs[i].name, "_we"},    64'(imem_we), 0);
            chk({vecs[i].name, "_count"}, 64'(count), 0);
         end
         chk({vecs[i].name, "_done"},  64'(done), 1);
         chk({vecs[i].name, "_err"},   64'(err_code), 64'(vecs[i].err));
         chk({vecs[i].name, "_nwr"},   64'(wr_cnt - wr_base), (vecs[i].err == 2'b00) ? 1 : 0);
      end

      // Multi-beat load, start ignored in ACCEPT.
      wr_base = wr_cnt;
      do_start();
      chk("new_load_done_clr", 64'(done), 0);
      chk("new_load_err_clr",  64'(err_code), 0);
      send(5'd8, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 1'b0);
      chk("add_we", 64'(imem_we), 1);
      chk("add_wdata", 64'(imem_wdata), 64'h8B020023);
      chk("add_ready_low", 64'(in_ready), 0);
      @(negedge clk);
      chk("add_ready_back", 64'(in_ready), 1);
      chk("add_count", 64'(count), 1);
      chk("add_we_one_cycle", 64'(imem_we), 0);
      do_start();
      chk("start_ign_addr", 64'(imem_addr), 1);
      chk("start_ign_count", 64'(count), 1);
      send(5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd1, 1'b1);
      chk("b_addr", 64'(imem_addr), 1);
      chk("b_wdata", 64'(imem_wdata), 64'h14000001);
      @(negedge clk);
      chk("ab_done", 64'(done), 1);
      chk("ab_count", 64'(count), 2);
      chk("ab_writes", 64'(wr_cnt - wr_base), 2);

      // in_valid while DONE has no effect, done/count hold.
      wr_base = wr_cnt;
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("done_hold", 64'(done), 1);
      chk("done_hold_count", 64'(count), 2);
      chk("done_no_write", 64'(wr_cnt - wr_base), 0);

      // Three-beat program.
      do_start();
      send(5'd3, 5'd1, 5'd0, 5'd0, 6'd0, 26'd5, 1'b0);
      chk("p3_addr0", 64'(imem_addr), 0);
      chk("p3_w0", 64'(imem_wdata), 64'h91001401);
      send(5'd16, 5'd2, 5'd1, 5'd0, 6'd0, 26'h3FFFFF8, 1'b0);
      chk("p3_addr1", 64'(imem_addr), 1);
      chk("p3_w1", 64'(imem_wdata), 64'hF85F8022);
      send(5'd1, 5'd4, 5'd0, 5'd0, 6'd0, 26'h3FFFFFE, 1'b1);
      chk("p3_addr2", 64'(imem_addr), 2);
      chk("p3_w2", 64'(imem_wdata), 64'hB4FFFFC4);
      @(negedge clk);
      chk("p3_done", 64'(done), 1);
      chk("p3_err", 64'(err_code), 0);
      chk("p3_count", 64'(count), 3);

      // Overflow: 256 beats without in_last.
      wr_base = wr_cnt;
      do_start();
      for (int i = 0; i < 256; i++) begin
         send(5'd8, 5'(i), 5'd1, 5'd2, 6'd0, 26'd0, 1'b0);
         chk($sformatf("ovf_we_%0d", i), 64'(imem_we), 1);
         chk($sformatf("ovf_addr_%0d", i), 64'(imem_addr), 64'(i));
      end
      @(negedge clk);
      chk("ovf_done", 64'(done), 1);
      chk("ovf_err", 64'(err_code), 3);
      chk("ovf_count", 64'(count), 256);
      chk("ovf_addr_hold", 64'(imem_addr), 255);
      chk("ovf_ready", 64'(in_ready), 0);
      chk("ovf_writes", 64'(wr_cnt - wr_base), 256);

      // Reset during WRITE suppresses the strobe.
      do_start();
      wr_base = wr_cnt;
      send(5'd8, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 1'b0);
      chk("rst_pre_we", 64'(imem_we), 1);
      #1 rst_n = 1'b0;
      #1 chk_reset("async_rst");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_no_strobe", 64'(wr_cnt - wr_base), 0);
      chk_reset("post_rst");

      // in_valid without start.
      mnem = 5'd8; in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("nostart_no_write", 64'(wr_cnt - wr_base), 0);
      chk("nostart_ready", 64'(in_ready), 0);
      chk("nostart_count", 64'(count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be:
  clk  in  1  rising-edge clock
  rst_n  in  1  async active-low reset
  start  in  1  one-cycle pulse, begins a program load at word address 0
  in_valid  in  1  instruction beat valid
  in_ready  out  1  block can accept a beat
  in_last  in  1  beat is final instruction of program
  mnem  in  5  0 B, 1 CBZ, 2 CBNZ, 3 ADDI, 4 ANDI, 5 EORI, 6 ORRI, 7 SUBI, 8 ADD, 9 AND, 10 BR, 11 EOR, 12 LSL, 13 LSR, 14 ORR, 15 SUB, 16 LDUR, 17 STUR; 18-31 illegal
  rd  in  5  Rd/Rt field
  rn  in  5  Rn field
  rm  in  5  Rm field
  shamt  in  6  shift amount (LSL/LSR)
  imm  in  26  two's-complement immediate/offset, in words for B/CB
  imem_we  out  1  instruction-memory write strobe
  imem_addr  out  8  word address
  imem_wdata  out  32  encoded instruction
  count  out  9  words written this load
  done  out  1  load finished
  err_code  out  2  00 ok, 01 illegal mnem, 10 imm out of range, 11 overflow

Function
REQ-003 Encodings SHALL be LEGv8: R = op[31:21], Rm[20:16], shamt[15:10], Rn[9:5], Rd[4:0]; I = op[31:22], imm12[21:10], Rn, Rd; D = op[31:21], imm9[20:12], 00[11:10], Rn, Rt; B = op[31:26], imm26[25:0]; CB = op[31:24], imm19[23:5], Rt[4:0].
REQ-004 Opcodes SHALL be: B 000101; CBZ 10110100; CBNZ 10110101; ADDI 1001000100; ANDI 1001001000; EORI 1101001000; ORRI 1011001000; SUBI 1101000100; ADD 10001011000; AND 10001010000; BR 11010110000; EOR 11001010000; LSL 11010011011; LSR 11010011010; ORR 10101010000; SUB 11001011000; LDUR 11111000010; STUR 11111000000.
REQ-005 LSL/LSR SHALL encode Rm=0 and shamt from input; other R-format (except BR) SHALL encode shamt=0; BR SHALL place rn in both [9:5] and [4:0], Rm=0, shamt=0.
REQ-006 Range rules: I-format imm SHALL be unsigned 0..4095; D-format signed -256..255; CB signed -262144..262143; B any 26-bit value; violation -> err_code 10.
REQ-007 States SHALL be IDLE, ACCEPT, WRITE, DONE; in_ready=1 only in ACCEPT.
REQ-008 IDLE or DONE + start -> ACCEPT; imem_addr<=0, count<=0, done<=0, err_code<=00; start in ACCEPT/WRITE SHALL be ignored.
REQ-009 ACCEPT + in_valid: legal beat -> encoded word registered to imem_wdata, go WRITE; illegal beat -> no write, err_code set, go DONE.
REQ-010 WRITE SHALL assert imem_we for exactly one cycle at current imem_addr, then increment imem_addr and count.
REQ-011 After WRITE: in_last=1 (captured with beat) -> DONE; imem_addr was 255 and in_last=0 -> DONE with err_code 11; else ACCEPT.
REQ-012 Latency: beat accepted at edge N -> imem_we high cycle N+1 -> in_ready high again cycle N+2 (max one beat per 2 cycles).
REQ-013 done SHALL be 1 in DONE and hold, with err_code and count, until next start.
REQ-014 imem_addr SHALL never wrap; addr 255 written at most once per load.
REQ-015 in_valid outside ACCEPT SHALL have no effect.

Reset
REQ-016 rst_n low SHALL force IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err_code=00, immediately and irrespective of clk.
REQ-017 Reset asserted mid-WRITE SHALL suppress the pending strobe; no write after release until new start.

Verification
REQ-018 start; ADD rd=3 rn=1 rm=2 last=0 -> imem_we at addr 0, wdata 0x8B020023, count 1, in_ready back high.
REQ-019 ADDI rd=1 rn=0 imm=5 -> 0x91001401; LDUR rd=2 rn=1 imm=-8 -> 0xF85F8022; CBZ rd=4 imm=-2 last=1 -> 0xB4FFFFC4, done=1, err 00, count 3.
REQ-020 ADDI imm=4096 -> no imem_we, done=1, err_code 10; mnem=20 -> err_code 01.
REQ-021 256 beats all in_last=0 -> addr 0..255 each written once, then done=1, err_code 11, count 256.
REQ-022 rst_n low during WRITE -> no strobe, all outputs at reset values; in_valid without start -> no write.
